// File: rtl/grid_scan.sv
// 8x8 LED grid scanner: double-buffered generation (shadow -> display at frame end),
// row-multiplexed BLANK/DRIVE scan. Optional brightness input under `GRID_SCAN_DIM_EN.
module grid_scan #(
  parameter int DWELL     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] gridin,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic [7:0]  row_out,
  output logic [7:0]  col_n,
  output logic        frame_done
`ifdef GRID_SCAN_DIM_EN
  ,
  input  logic [2:0]  dim
`endif
);

  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t        state, state_d;
  logic [2:0]    row, row_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [63:0]   shadow, display, display_d;
  logic          shadow_full;
  logic          swap, accept, drive_cols;

`ifdef GRID_SCAN_DIM_EN
  // Columns stay lit for the first (dim+1)/8 of the dwell.
  function automatic logic dim_on(input logic [CW-1:0] c, input logic [2:0] lvl);
    logic [CW+3:0] lim;
    lim = (CW+4)'({1'b0, lvl} + 4'd1) * (CW+4)'(DWELL / 8);
    return {4'b0000, c} < lim;
  endfunction

  assign drive_cols = dim_on(cnt_d, dim);
`else
  assign drive_cols = 1'b1;
`endif

  assign grid_ready = ~shadow_full;
  // Swap needs a full shadow while accept needs an empty one, so they never coincide.
  assign swap       = frame_done & shadow_full;
  assign accept     = grid_valid & ~shadow_full;
  assign display_d  = swap ? shadow : display;

  always_comb begin
    state_d = state;
    row_d   = row;
    cnt_d   = cnt;
    if (!enable) begin
      state_d = BLANK;
      row_d   = '0;
      cnt_d   = '0;
    end else if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_d = DRIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end else begin
      if (cnt == DWELL_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        row_d   = row + 3'd1;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  // Outputs are registered from next-state so they align with state and never see inputs combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      row         <= '0;
      cnt         <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      display     <= '0;
      row_out     <= 8'h00;
      col_n       <= 8'hFF;
      frame_done  <= 1'b0;
    end else begin
      state   <= state_d;
      row     <= row_d;
      cnt     <= cnt_d;
      display <= display_d;
      if (swap) begin
        shadow_full <= 1'b0;
      end else if (accept) begin
        shadow      <= gridin;
        shadow_full <= 1'b1;
      end
      frame_done <= (state_d == DRIVE) && (row_d == 3'd7) && (cnt_d == DWELL_LAST);
      row_out    <= (state_d == DRIVE) ? (8'h01 << row_d) : 8'h00;
      col_n      <= ((state_d == DRIVE) && drive_cols) ? ~display_d[{row_d, 3'b000} +: 8] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_grid_scan.sv
// Bench for grid_scan (DWELL=8, BLANK_CYC=1); the model tracks frame position as one cycle index.
module tb_grid_scan;

  localparam int DWELL     = 8;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = BLANK_CYC + DWELL;
  localparam int FRAME     = 8 * SLOT;
`ifdef GRID_SCAN_DIM_EN
  localparam bit DIM_EN = 1'b1;
`else
  localparam bit DIM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, grid_valid, grid_ready, frame_done;
  logic [63:0] gridin;
  logic [7:0]  row_out, col_n;
  logic [2:0]  dim;

  int checks   = 0;
  int failures = 0;

  int          m_t = 0;
  logic [63:0] m_disp = '0, m_shadow = '0;
  bit          m_full = 1'b0;
  logic [2:0]  m_dim = 3'd7;

  grid_scan #(.DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .gridin     (gridin),
    .grid_valid (grid_valid),
    .grid_ready (grid_ready),
    .row_out    (row_out),
    .col_n      (col_n),
    .frame_done (frame_done)
`ifdef GRID_SCAN_DIM_EN
    ,
    .dim        (dim)
`endif
  );

  always #5 clk = ~clk;

  // Expected {row_out, col_n, frame_done, grid_ready} for the current cycle.
  function automatic logic [17:0] exp_out();
    int row, ph, lim;
    bit drv;
    logic [7:0] ro, cn;
    row = m_t / SLOT;
    ph  = m_t % SLOT;
    drv = (ph >= BLANK_CYC);
    lim = DIM_EN ? ((int'(m_dim) + 1) * DWELL) / 8 : DWELL;
    ro  = drv ? 8'(1 << row) : 8'h00;
    cn  = 8'hFF;
    if (drv && (ph - BLANK_CYC) < lim) cn = ~m_disp[row*8 +: 8];
    return {ro, cn, (m_t == FRAME - 1), !m_full};
  endfunction

  task automatic tick();
    int nt;
    logic [63:0] nd, ns;
    bit nf;
    logic [2:0] nm;
    nm = dim;
    if (reset) begin
      nt = 0; nd = '0; ns = '0; nf = 1'b0;
    end else begin
      nt = enable ? (m_t + 1) % FRAME : 0;
      nd = m_disp; ns = m_shadow; nf = m_full;
      if (m_t == FRAME - 1 && m_full) begin
        nd = m_shadow; nf = 1'b0;
      end else if (grid_valid && !m_full) begin
        ns = gridin; nf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_t = nt; m_disp = nd; m_shadow = ns; m_full = nf; m_dim = nm;
  endtask

  task automatic do_reset();
    reset = 1'b1; grid_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; grid_valid = 1'b0; gridin = '0;
    tick(); tick();
    checks++; if (row_out !== 8'h00) begin failures++; $display("FAIL reset_row_out got=%h exp=00", row_out); end
    checks++; if (col_n !== 8'hFF) begin failures++; $display("FAIL reset_col_n got=%h exp=FF", col_n); end
    checks++; if (grid_ready !== 1'b1) begin failures++; $display("FAIL reset_grid_ready got=%b exp=1", grid_ready); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    reset = 1'b0;
  endtask

  task automatic test_scan_basic();
    logic [17:0] obs, exp;
    int fd_first, f1_lit, f2_row0, f2_other;
    fd_first = 0; f1_lit = 0; f2_row0 = 0; f2_other = 0;
    enable = 1'b1;
    do_reset();
    gridin = 64'h00000000000000FF;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL scan_basic n=%0d got=%h exp=%h", n, obs, exp); end
      if (frame_done === 1'b1 && fd_first == 0) fd_first = n;
      if (n <= FRAME && col_n !== 8'hFF) f1_lit++;
      if (n > FRAME && col_n === 8'h00 && row_out === 8'h01) f2_row0++;
      if (n > FRAME && col_n !== 8'hFF && row_out !== 8'h01) f2_other++;
      grid_valid = (n == 1);
      tick();
    end
    grid_valid = 1'b0;
    checks++; if (fd_first != FRAME) begin failures++; $display("FAIL first_frame_done cycle=%0d exp=%0d", fd_first, FRAME); end
    checks++; if (f1_lit != 0) begin failures++; $display("FAIL frame1_blank lit_cycles=%0d exp=0", f1_lit); end
    checks++; if (f2_row0 != DWELL) begin failures++; $display("FAIL frame2_row0 lit_cycles=%0d exp=%0d", f2_row0, DWELL); end
    checks++; if (f2_other != 0) begin failures++; $display("FAIL frame2_other_rows lit_cycles=%0d exp=0", f2_other); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] obs, exp;
    logic [63:0] g1, g2;
    int idx, fd_n, rdy_hi;
    int acc [2];
    idx = 0; fd_n = 0; rdy_hi = 0; acc[0] = 0; acc[1] = 0;
    g1 = {$urandom, $urandom}; g2 = {$urandom, $urandom};
    enable = 1'b1;
    do_reset();
    grid_valid = 1'b1; gridin = g1;
    for (int n = 1; n <= 3 * FRAME; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL back_to_back n=%0d got=%h exp=%h", n, obs, exp); end
      if (frame_done === 1'b1 && fd_n == 0) fd_n = n;
      if (idx == 1 && fd_n == 0 && grid_ready === 1'b1) rdy_hi++;
      if (idx < 2 && grid_valid && grid_ready === 1'b1) begin
        acc[idx] = n; idx++;
      end
      grid_valid = (idx < 2);
      gridin = (idx == 0) ? g1 : g2;
      tick();
    end
    grid_valid = 1'b0;
    checks++; if (acc[0] != 1) begin failures++; $display("FAIL b2b_first_accept cycle=%0d exp=1", acc[0]); end
    checks++; if (rdy_hi != 0) begin failures++; $display("FAIL b2b_ready_low ready_high_cycles=%0d exp=0", rdy_hi); end
    checks++; if (acc[1] != FRAME + 1) begin failures++; $display("FAIL b2b_second_accept cycle=%0d exp=%0d", acc[1], FRAME + 1); end
  endtask

  task automatic test_enable_drop();
    logic [17:0] obs, exp;
    logic [63:0] g;
    g = {$urandom, $urandom} | 64'h0101010101010101;
    enable = 1'b1;
    do_reset();
    gridin = g;
    for (int n = 1; n < FRAME + 3 * SLOT + BLANK_CYC + 3; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL en_lead n=%0d got=%h exp=%h", n, obs, exp); end
      grid_valid = (n == 1);
      tick();
    end
    grid_valid = 1'b0;
    checks++; if (row_out !== 8'h08) begin failures++; $display("FAIL en_row3_drive got=%h exp=08", row_out); end
    enable = 1'b0;
    tick();
    checks++; if (row_out !== 8'h00) begin failures++; $display("FAIL en_drop_row got=%h exp=00", row_out); end
    checks++; if (col_n !== 8'hFF) begin failures++; $display("FAIL en_drop_col got=%h exp=FF", col_n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL en_hold i=%0d got=%h exp=%h", i, obs, exp); end
    end
    enable = 1'b1;
    checks++; if (row_out !== 8'h00) begin failures++; $display("FAIL en_restart_blank got=%h exp=00", row_out); end
    tick();
    checks++; if (row_out !== 8'h01) begin failures++; $display("FAIL en_restart_row0 got=%h exp=01", row_out); end
    checks++; if (col_n !== ~g[7:0]) begin failures++; $display("FAIL en_restart_col got=%h exp=%h", col_n, ~g[7:0]); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] obs, exp;
    logic [63:0] g1, g2;
    int lit, fds;
    lit = 0; fds = 0;
    g1 = {$urandom, $urandom} | 64'h0101010101010101;
    g2 = {$urandom, $urandom} | 64'h0202020202020202;
    enable = 1'b1;
    do_reset();
    for (int n = 1; n < FRAME + 40; n++) begin
      grid_valid = (n == 1) || (n == FRAME + 2);
      gridin = (n == 1) ? g1 : g2;
      tick();
    end
    grid_valid = 1'b0;
    checks++; if (grid_ready !== 1'b0) begin failures++; $display("FAIL rmid_shadow_pending ready=%b exp=0", grid_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (grid_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", grid_ready); end
    for (int n = 1; n <= FRAME; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL rmid_frame n=%0d got=%h exp=%h", n, obs, exp); end
      if (col_n !== 8'hFF) lit++;
      if (frame_done === 1'b1) fds++;
      tick();
    end
    checks++; if (lit != 0) begin failures++; $display("FAIL rmid_blank lit_cycles=%0d exp=0", lit); end
    checks++; if (fds != 1) begin failures++; $display("FAIL rmid_frame_done pulses=%0d exp=1", fds); end
  endtask

  task automatic test_random();
    logic [17:0] obs, exp;
    int errs;
    errs = 0;
    enable = 1'b1;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; errs++; if (errs < 10) $display("FAIL random n=%0d got=%h exp=%h", n, obs, exp); end
      reset      = ($urandom_range(0, 499) == 0);
      enable     = ($urandom_range(0, 299) != 0);
      grid_valid = ($urandom_range(0, 19) == 0);
      gridin     = {$urandom, $urandom};
      dim        = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; grid_valid = 1'b0; enable = 1'b1; dim = 3'd7;
  endtask

  task automatic test_dim();
    logic [17:0] obs, exp;
    int on3, on7;
    on3 = 0; on7 = 0;
    enable = 1'b1; dim = 3'd3;
    do_reset();
    gridin = '1;
    for (int n = 1; n <= 3 * FRAME; n++) begin
      obs = {row_out, col_n, frame_done, grid_ready}; exp = exp_out();
      checks++; if (obs !== exp) begin failures++; $display("FAIL dim n=%0d got=%h exp=%h", n, obs, exp); end
      if (n > FRAME && n <= 2 * FRAME && col_n === 8'h00) on3++;
      if (n > 2 * FRAME && col_n === 8'h00) on7++;
      grid_valid = (n == 1);
      if (n == 2 * FRAME) dim = 3'd7;
      tick();
    end
    grid_valid = 1'b0;
    checks++; if (on3 != 8 * 4) begin failures++; $display("FAIL dim3_lit cycles=%0d exp=%0d", on3, 8 * 4); end
    checks++; if (on7 != 8 * DWELL) begin failures++; $display("FAIL dim7_lit cycles=%0d exp=%0d", on7, 8 * DWELL); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; grid_valid = 1'b0; gridin = '0; dim = 3'd7;
    test_reset();
    test_scan_basic();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_random();
    if (DIM_EN) test_dim();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_scan.md
GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 Parameter: DWELL, 16, clock cycles each row is driven per frame (>=2).
REQ-002 Parameter: BLANK_CYC, 2, blanking cycles before each row (>=1).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  scan enable; low = display blanked and held.
REQ-006 Port: gridin  input  64  8x8 generation; bit 8*r+c = cell row r, column c (1 = live).
REQ-007 Port: grid_valid  input  1  gridin holds a new generation.
REQ-008 Port: grid_ready  output  1  shadow buffer empty; transfer occurs when grid_valid && grid_ready.
REQ-009 Port: row_out  output  8  one-hot active-high row select.
REQ-010 Port: col_n  output  8  active-low column drive; col_n[c] = ~cell(r,c).
REQ-011 Port: frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-012 Two 64-bit registers SHALL be kept: shadow (with shadow_full flag) and display.
REQ-013 grid_ready SHALL equal !shadow_full; accept cycle loads shadow <= gridin and sets shadow_full.
REQ-014 gridin SHALL be ignored when grid_valid && !grid_ready; the writer holds until ready.
REQ-015 FSM states: BLANK (row_out=0, col_n=8'hFF) and DRIVE (row_out=1<<row, col_n=~display[8*row+:8]).
REQ-016 BLANK SHALL last BLANK_CYC cycles, then DRIVE for DWELL cycles, then BLANK with row+1 (row wraps 7->0).
REQ-017 Frame length SHALL be exactly 8*(BLANK_CYC+DWELL) cycles while enable stays high.
REQ-018 frame_done SHALL be high only during the last DRIVE cycle of row 7.
REQ-019 At the edge ending that cycle, if shadow_full: display <= shadow and shadow_full cleared; new data visible from the following row-0 DRIVE.
REQ-020 Accept and swap in the same cycle cannot collide (ready low when full); a grid accepted on the frame_done cycle SHALL wait for the next frame boundary.
REQ-021 enable low SHALL force BLANK from the next cycle, reset row and cycle counters to 0 and suppress frame_done; handshake and shadow SHALL keep operating.
REQ-022 On enable rising, scanning SHALL restart at BLANK, row 0, full BLANK_CYC.
REQ-023 row_out, col_n, frame_done SHALL decode from registered state only (no combinational input-to-output path).

Reset
REQ-024 reset SHALL set state BLANK, row 0, counters 0, display 0, shadow 0, shadow_full 0.
REQ-025 During and after reset: row_out=8'h00, col_n=8'hFF, frame_done=0, grid_ready=1.
REQ-026 reset mid-frame SHALL discard a pending shadow grid and the displayed grid; takes priority over enable and handshake.

Configuration
REQ-027 Macro GRID_SCAN_DIM_EN SHALL add input dim[2:0] (brightness level).
REQ-028 With GRID_SCAN_DIM_EN: in DRIVE, columns driven only while dwell count < ((dim+1)*DWELL)/8, else col_n=8'hFF (row_out unchanged); DWELL SHALL be a multiple of 8.
REQ-029 Without GRID_SCAN_DIM_EN: no dim port; columns driven for the full DWELL.

Verification (DWELL=8, BLANK_CYC=1, frame = 72 cycles)
REQ-030 Reset asserted 2 cycles -> row_out=00, col_n=FF, grid_ready=1, frame_done=0.
REQ-031 enable=1, push gridin=64'h00000000000000FF -> frame 1 all columns FF; frame_done at cycle 72; frame 2 row 0 DRIVE col_n=00, rows 1-7 col_n=FF.
REQ-032 Two back-to-back valids -> first accepted, grid_ready low until frame_done edge, second accepted the cycle after swap.
REQ-033 enable dropped during row 3 DRIVE -> next cycle row_out=00, col_n=FF; re-enable -> 1 BLANK cycle then row 0 DRIVE.
REQ-034 reset mid-frame with shadow_full=1 -> grid_ready=1, subsequent frame fully blank columns.
REQ-035 GRID_SCAN_DIM_EN, dim=3, display all ones -> col_n=00 for 4 of 8 DRIVE cycles per row, FF for remaining 4; dim=7 -> all 8.
